// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core sequencer: state encoding, instruction-word layout, idle word.
package core_ctrl_pkg;

  localparam int unsigned AddrW = 11;
  localparam int unsigned InstW = 34;

  typedef enum logic [2:0] {
    StIdle,
    StWFetch,
    StWLoad,
    StSettle,
    StXFetch,
    StExec,
    StDrain,
    StDone
  } seq_state_e;

  // Instruction word bit positions.
  localparam int unsigned PmemCenBit  = 32;
  localparam int unsigned PmemWenBit  = 31;
  localparam int unsigned PmemAddrLsb = 20;
  localparam int unsigned XmemCenBit  = 19;
  localparam int unsigned XmemWenBit  = 18;
  localparam int unsigned XmemAddrLsb = 7;
  localparam int unsigned OfifoRdBit  = 6;
  localparam int unsigned IfifoWrBit  = 5;
  localparam int unsigned IfifoRdBit  = 4;
  localparam int unsigned L0RdBit     = 3;
  localparam int unsigned L0WrBit     = 2;
  localparam int unsigned ExecBit     = 1;
  localparam int unsigned LoadBit     = 0;

  // All SRAM enables/writes inactive, addresses and strobes zero.
  localparam logic [InstW-1:0] IdleWord = 34'h1_800C_0000;

  // SRAM addresses wrap modulo 2048.
  function automatic logic [AddrW-1:0] addr_add(input logic [AddrW-1:0] base,
                                                input logic [AddrW-1:0] off);
    return base + off;
  endfunction

endpackage

// File: rtl/seq_counter.sv
// 11-bit phase counter: synchronous load, increment, and compare against a terminal value.
module seq_counter
  import core_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [AddrW-1:0] load_val_i,
  input  logic             inc_i,
  input  logic [AddrW-1:0] term_i,
  output logic [AddrW-1:0] cnt_o,
  output logic             term_o
);

  logic [AddrW-1:0] cnt_d, cnt_q;

  // Load has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == term_i);

endmodule

// File: rtl/core_sequencer.sv
// Tile sequencer: weight fetch/load, settle, activation fetch/execute, and OFIFO drain to psum SRAM.
module core_sequencer
  import core_ctrl_pkg::*;
#(
  parameter int unsigned row    = 8,
  parameter int unsigned col    = 8,
  parameter int unsigned settle = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AddrW-1:0] x_len,
  input  logic [AddrW-1:0] w_base,
  input  logic [AddrW-1:0] x_base,
  input  logic [AddrW-1:0] p_base,
  input  logic             ofifo_valid,
  output logic [InstW-1:0] inst,
  output logic             xw_mode,
  output logic             pmem_mode,
  output logic             busy,
  output logic             done
);

  // Zero-sized phases would make the terminal compares wrap around.
  if (row == 0 || col == 0 || settle == 0) begin : g_param_check
    $error("core_sequencer: row, col and settle must be non-zero");
  end

  seq_state_e state_d, state_q;

  logic [AddrW-1:0] xlen_q, wbase_q, xbase_q, pbase_q;
  logic [InstW-1:0] inst_d, inst_q;
  logic             xw_mode_d, xw_mode_q;
  logic             busy_q, done_q, pmem_mode_q;
  logic             cap;

  // Weight-side counter (W_FETCH, W_LOAD, SETTLE), activation-side (X_FETCH, EXEC), drain k.
  logic             w_load, w_inc, w_hit;
  logic             x_load, x_inc, x_hit;
  logic             d_load, d_inc, d_hit;
  logic [AddrW-1:0] w_cnt, x_cnt, d_cnt;
  logic [AddrW-1:0] w_term, x_term;

  assign w_term = (state_q == StSettle) ? AddrW'(settle - 1) : AddrW'(col - 1);
  assign x_term = xlen_q - 1'b1;

  seq_counter u_wcnt (
    .clk_i     (clk),
    .rst_i     (reset),
    .load_i    (w_load),
    .load_val_i('0),
    .inc_i     (w_inc),
    .term_i    (w_term),
    .cnt_o     (w_cnt),
    .term_o    (w_hit)
  );

  seq_counter u_xcnt (
    .clk_i     (clk),
    .rst_i     (reset),
    .load_i    (x_load),
    .load_val_i('0),
    .inc_i     (x_inc),
    .term_i    (x_term),
    .cnt_o     (x_cnt),
    .term_o    (x_hit)
  );

  seq_counter u_dcnt (
    .clk_i     (clk),
    .rst_i     (reset),
    .load_i    (d_load),
    .load_val_i('0),
    .inc_i     (d_inc),
    .term_i    (xlen_q),
    .cnt_o     (d_cnt),
    .term_o    (d_hit)
  );

  // Next state, counter control and next instruction word.
  always_comb begin
    state_d   = state_q;
    cap       = 1'b0;
    w_load    = 1'b0;
    w_inc     = 1'b0;
    x_load    = 1'b0;
    x_inc     = 1'b0;
    d_load    = 1'b0;
    d_inc     = 1'b0;
    xw_mode_d = 1'b0;
    inst_d    = IdleWord;
    // SRAM data arrives one cycle after the read, so L0 is written a cycle later.
    inst_d[L0WrBit] = ~inst_q[XmemCenBit];

    unique case (state_q)
      StIdle: begin
        if (start) begin
          cap     = 1'b1;
          w_load  = 1'b1;
          x_load  = 1'b1;
          d_load  = 1'b1;
          state_d = (x_len == '0) ? StDone : StWFetch;
        end
      end
      StWFetch: begin
        xw_mode_d                       = 1'b1;
        inst_d[XmemCenBit]              = 1'b0;
        inst_d[XmemAddrLsb +: AddrW]    = addr_add(wbase_q, w_cnt);
        w_inc                           = 1'b1;
        if (w_hit) begin
          w_load  = 1'b1;
          state_d = StWLoad;
        end
      end
      StWLoad: begin
        // Keep the weight SRAM selected for the data of the final read.
        xw_mode_d       = 1'b1;
        inst_d[LoadBit] = 1'b1;
        inst_d[L0RdBit] = 1'b1;
        w_inc           = 1'b1;
        if (w_hit) begin
          w_load  = 1'b1;
          state_d = StSettle;
        end
      end
      StSettle: begin
        w_inc = 1'b1;
        if (w_hit) begin
          state_d = StXFetch;
        end
      end
      StXFetch: begin
        inst_d[XmemCenBit]           = 1'b0;
        inst_d[XmemAddrLsb +: AddrW] = addr_add(xbase_q, x_cnt);
        x_inc                        = 1'b1;
        if (x_hit) begin
          x_load  = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        inst_d[ExecBit] = 1'b1;
        inst_d[L0RdBit] = 1'b1;
        x_inc           = 1'b1;
        if (x_hit) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (d_hit) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Drain runs alongside EXEC; the OFIFO is show-ahead so pop and psum write share a word.
    if ((state_q == StExec || state_q == StDrain) && ofifo_valid && !d_hit) begin
      inst_d[OfifoRdBit]            = 1'b1;
      inst_d[PmemCenBit]            = 1'b0;
      inst_d[PmemWenBit]            = 1'b0;
      inst_d[PmemAddrLsb +: AddrW]  = addr_add(pbase_q, d_cnt);
      d_inc                         = 1'b1;
    end
  end

  // State, captured tile parameters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      xlen_q      <= '0;
      wbase_q     <= '0;
      xbase_q     <= '0;
      pbase_q     <= '0;
      inst_q      <= IdleWord;
      xw_mode_q   <= 1'b0;
      pmem_mode_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      inst_q      <= inst_d;
      xw_mode_q   <= xw_mode_d;
      pmem_mode_q <= 1'b0;
      busy_q      <= (state_d != StIdle);
      done_q      <= (state_q == StDone);
      if (cap) begin
        xlen_q  <= x_len;
        wbase_q <= w_base;
        xbase_q <= x_base;
        pbase_q <= p_base;
      end
    end
  end

  assign inst      = inst_q;
  assign xw_mode   = xw_mode_q;
  assign pmem_mode = pmem_mode_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Randomised self-checking bench for core_sequencer against a transaction-level reference.
module tb_core_sequencer;

  localparam int unsigned COL    = 8;
  localparam int unsigned SETTLE = 16;
  localparam logic [33:0] IDLE   = 34'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] x_len, w_base, x_base, p_base;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        xw_mode, pmem_mode, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  core_sequencer #(
    .row   (8),
    .col   (COL),
    .settle(SETTLE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .x_len      (x_len),
    .w_base     (w_base),
    .x_base     (x_base),
    .p_base     (p_base),
    .ofifo_valid(ofifo_valid),
    .inst       (inst),
    .xw_mode    (xw_mode),
    .pmem_mode  (pmem_mode),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Canonical word for the strobes present in w; anything else must be idle.
  function automatic logic [33:0] rebuild(input logic [33:0] w);
    logic [33:0] r;
    r = IDLE;
    if (!w[19]) begin
      r[19]    = 1'b0;
      r[17:7]  = w[17:7];
    end
    if (!w[32]) begin
      r[32]    = 1'b0;
      r[31]    = 1'b0;
      r[30:20] = w[30:20];
      r[6]     = 1'b1;
    end
    r[3] = w[0] | w[1];
    r[2] = w[2];
    r[1] = w[1];
    r[0] = w[0];
    return r;
  endfunction

  // Runs one tile. vmode: 0 valid always, 1 random valid, 2 gapped bursts after EXEC starts.
  // poke: step at which a second start is asserted mid-tile (0 = none).
  task automatic run_tile(input logic [10:0] wb, input logic [10:0] xb, input logic [10:0] pb,
                          input logic [10:0] xl, input int vmode, input int poke);
    logic [10:0] rd_q[$];
    bit          rd_xw[$];
    logic [10:0] wr_q[$];
    logic [33:0] w;
    logic [10:0] ea;
    int loads = 0, execs = 0, first_load = -1, last_load = -1;
    int first_exec = -1, last_exec = -1, first_xrd = -1, first_wr = -1, last_wr = -1;
    int done_cnt = 0, done_step = -1, busy_err = 0, l0wr_err = 0, shape_err = 0, wr_err = 0;
    int t_exec = -1;
    bit prev_rd = 1'b0, prev_valid, v;
    w_base = wb;
    x_base = xb;
    p_base = pb;
    x_len  = xl;
    start  = 1'b1;
    ofifo_valid = (vmode == 0);
    prev_valid  = ofifo_valid;
    for (int s = 1; s < 2000; s++) begin
      @(posedge clk);
      #1;
      start = (s == poke);
      x_len = (s == poke) ? 11'd7 : xl;
      w = inst;
      if (w[33] || w[5] || w[4]) shape_err++;
      if (w !== rebuild(w)) shape_err++;
      if (w[2] != prev_rd) l0wr_err++;
      prev_rd = !w[19];
      if (!w[19]) begin
        rd_q.push_back(w[17:7]);
        rd_xw.push_back(xw_mode);
        if (rd_q.size() == COL + 1) first_xrd = s;
      end
      if (w[0]) begin
        loads++;
        if (first_load < 0) first_load = s;
        last_load = s;
      end
      if (w[1]) begin
        execs++;
        if (first_exec < 0) first_exec = s;
        last_exec = s;
      end
      if (!w[32]) begin
        wr_q.push_back(w[30:20]);
        if (first_wr < 0) first_wr = s;
        last_wr = s;
        if (!prev_valid) wr_err++;
      end
      if (done) begin
        done_cnt++;
        if (done_step < 0) done_step = s;
      end
      if (done_step < 0 && !busy) busy_err++;
      if (done_step >= 0 && busy) busy_err++;
      if (done_step >= 0 && s >= done_step + 3) break;
      if (w[1] && t_exec < 0) t_exec = 0;
      else if (t_exec >= 0) t_exec++;
      case (vmode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(0, 2) != 0);
        default: v = (t_exec inside {0, 1, 4, 8, 9}) || (t_exec >= 12);
      endcase
      ofifo_valid = v;
      prev_valid  = v;
    end
    start = 1'b0;
    ofifo_valid = 1'b0;

    check_eq("done_count", done_cnt, 1);
    check_eq("busy_profile_errs", busy_err, 0);
    check_eq("inst_shape_errs", shape_err, 0);
    check_eq("l0_wr_lag_errs", l0wr_err, 0);
    check_eq("read_count", rd_q.size(), COL + xl);
    for (int i = 0; i < rd_q.size() && i < COL + xl; i++) begin
      ea = (i < COL) ? wb + 11'(i) : xb + 11'(i - COL);
      check_eq("read_addr", rd_q[i], ea);
      check_eq("read_xw_mode", rd_xw[i], (i < COL));
    end
    check_eq("load_cycles", loads, COL);
    check_eq("load_contiguous", last_load - first_load + 1, COL);
    check_eq("exec_cycles", execs, xl);
    check_eq("exec_contiguous", last_exec - first_exec + 1, xl);
    check_eq("settle_gap", first_xrd - last_load - 1, SETTLE);
    check_eq("write_count", wr_q.size(), xl);
    for (int k = 0; k < wr_q.size() && k < xl; k++) begin
      ea = pb + 11'(k);
      check_eq("write_addr", wr_q[k], ea);
    end
    check_eq("write_without_valid", wr_err, 0);
    check_eq("done_after_last_write", (done_step > last_wr), 1);
    if (vmode == 0) check_eq("drain_overlaps_exec", (first_wr >= 0 && first_wr <= last_exec), 1);
  endtask

  task automatic run_zero_len();
    int done_cnt = 0, done_step = -1, nonidle = 0;
    bit busy1 = 1'b0, busy2 = 1'b1;
    x_len  = 11'd0;
    w_base = 11'd3;
    x_base = 11'd9;
    p_base = 11'd27;
    start  = 1'b1;
    ofifo_valid = 1'b1;
    for (int s = 1; s <= 5; s++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (inst !== IDLE) nonidle++;
      if (done) begin
        done_cnt++;
        done_step = s;
      end
      if (s == 1) busy1 = busy;
      if (s == 2) busy2 = busy;
    end
    ofifo_valid = 1'b0;
    check_eq("zero_len_done_count", done_cnt, 1);
    check_eq("zero_len_done_step", done_step, 2);
    check_eq("zero_len_busy_step1", busy1, 1);
    check_eq("zero_len_busy_step2", busy2, 0);
    check_eq("zero_len_nonidle", nonidle, 0);
  endtask

  task automatic run_reset_mid_tile();
    int guard = 0, dones = 0, nonidle = 0;
    x_len  = 11'd6;
    w_base = 11'(($urandom));
    x_base = 11'(($urandom));
    p_base = 11'(($urandom));
    start  = 1'b1;
    ofifo_valid = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (!inst[1] && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check_eq("reached_exec", inst[1], 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_mid_inst", inst, IDLE);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_done", done, 0);
    check_eq("rst_mid_xw_mode", xw_mode, 0);
    check_eq("rst_mid_pmem_mode", pmem_mode, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int s = 0; s < 6; s++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
      if (inst !== IDLE || busy) nonidle++;
    end
    ofifo_valid = 1'b0;
    check_eq("rst_mid_no_done", dones, 0);
    check_eq("rst_mid_quiet", nonidle, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    x_len       = '0;
    w_base      = '0;
    x_base      = '0;
    p_base      = '0;
    ofifo_valid = 1'b0;
    #12;
    check_eq("reset_inst", inst, IDLE);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_xw_mode", xw_mode, 0);
    check_eq("reset_pmem_mode", pmem_mode, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_tile(11'd0, 11'd16, 11'd100, 11'd4, 0, 0);
    run_tile(11'd0, 11'd16, 11'd100, 11'd4, 2, 0);
    run_tile(11'd5, 11'd2046, 11'd2046, 11'd4, 0, 0);
    run_tile(11'd2044, 11'd300, 11'd700, 11'd5, 1, 10);
    run_tile(11'd40, 11'd50, 11'd60, 11'd3, 0, 30);
    run_zero_len();
    run_reset_mid_tile();
    run_tile(11'd0, 11'd16, 11'd100, 11'd4, 0, 0);
    for (int t = 0; t < 6; t++) begin
      run_tile(11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom_range(1, 12)),
               int'($urandom_range(0, 1)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 The module SHALL have parameter row, default 8, giving the number of PE rows (activation vector lanes).
REQ-002 The module SHALL have parameter col, default 8, giving the number of PE columns (weight vectors per tile).
REQ-003 The module SHALL have parameter settle, default 16, giving the idle cycles between weight load and activation execute.
REQ-004 Ports, in this order:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  asynchronous, active-high.
- start  input  1  single-cycle tile request, sampled only in IDLE.
- x_len  input  11  number of activation vectors in the tile, sampled on start.
- w_base  input  11  weight SRAM base address, sampled on start.
- x_base  input  11  activation SRAM base address, sampled on start.
- p_base  input  11  psum SRAM base address, sampled on start.
- ofifo_valid  input  1  core output FIFO holds a readable vector.
- inst  output  34  registered instruction word to the core.
- xw_mode  output  1  registered; 1 selects the weight SRAM, 0 selects the activation SRAM.
- pmem_mode  output  1  registered, held at 0 so psum writes come from the OFIFO.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the tile completes.

Function
REQ-005 The inst fields SHALL be: [32] pmem CEN, [31] pmem WEN, [30:20] pmem address, [19] xmem CEN, [18] xmem WEN, [17:7] xmem address, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load; bit 33 and bits 5:4 SHALL always be 0.
REQ-006 The idle word SHALL be 34'h1_800C_0000: all CEN/WEN high, addresses 0, strobes 0.
REQ-007 The FSM states SHALL be IDLE, W_FETCH, W_LOAD, SETTLE, X_FETCH, EXEC, DRAIN, DONE.
REQ-008 IDLE -> W_FETCH SHALL occur on start with x_len != 0; start with x_len == 0 SHALL go straight to DONE.
REQ-009 W_FETCH SHALL run col cycles with xw_mode=1 and a read at w_base+i.
- l0_wr SHALL be asserted one cycle after each read, to cover the SRAM read latency.
- The last l0_wr SHALL overlap the first W_LOAD cycle.
REQ-010 W_LOAD SHALL assert load=1 and l0_rd=1 for col cycles.
REQ-011 SETTLE SHALL emit the idle word for settle cycles.
REQ-012 X_FETCH SHALL run x_len cycles with xw_mode=0, a read at x_base+i, and l0_wr delayed one cycle as in W_FETCH.
REQ-013 EXEC SHALL assert execute=1 and l0_rd=1 for x_len cycles.
REQ-014 DRAIN SHALL, in each cycle where ofifo_valid=1, do both of the following in the same inst word, because the OFIFO is show-ahead:
- assert ofifo_rd;
- write pmem at p_base+k (CEN=0, WEN=0).
REQ-015 DRAIN SHALL also be entered in parallel: OFIFO draining SHALL begin while EXEC is still active, and the drain counter k SHALL be independent of the EXEC counter.
REQ-016 DRAIN SHALL exit to DONE when k reaches x_len.
REQ-017 DONE SHALL last one cycle, assert done=1, and return to IDLE.
REQ-018 All address arithmetic SHALL be 11-bit modulo 2048, wrapping without error.
REQ-019 A start received while busy=1 SHALL be ignored.
REQ-020 Outside the strobes listed for each state, inst SHALL equal the idle word.

Reset
REQ-021 Asserting reset SHALL, at any time, immediately force the following:
- state IDLE, all counters 0;
- inst = idle word;
- xw_mode=0, pmem_mode=0, busy=0, done=0.
REQ-022 Reset mid-tile SHALL abandon the tile with no done pulse, and the first start after release SHALL be accepted normally.

Structure
REQ-023 The state encoding, the inst bit-position constants and the idle-word constant SHALL live in a shared package, core_ctrl_pkg.
REQ-024 A single sub-module, seq_counter, SHALL be used: an 11-bit load/increment/terminal-compare counter instantiated for the fetch, execute and drain counts.

Verification
REQ-025 The bench SHALL cover these scenarios:
- Weight and activation phases: x_len=4, w_base=0, x_base=16, p_base=100, ofifo_valid=1 -> xmem reads at 0..7 then 16..19, each l0_wr exactly one cycle later, load high 8 cycles, execute high 4 cycles.
- Drain gaps: ofifo_valid pulsed in 3 gapped bursts -> pmem writes at 100..103, only in ofifo_valid cycles, then one done pulse and busy low.
- Address wrap: x_base=2046, x_len=4 -> xmem addresses 2046, 2047, 0, 1.
- Busy and zero length: start asserted while busy -> ignored; start with x_len=0 -> done two cycles later, no non-idle inst.
- Reset mid-tile: reset asserted during EXEC -> inst=34'h1_800C_0000 immediately, no done, and a subsequent start runs the full sequence.
